// File: rtl/axi_slave_mem.sv
// AXI4 slave with an internal word-addressed memory: one write and one read burst
// in flight at a time, FIXED/INCR/WRAP bursts, byte strobes and OKAY/SLVERR responses.
module axi_slave_mem #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);
    localparam logic [2:0]          MAX_SIZE  = 3'(OFF);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            size,
        input logic [LEN_WIDTH-1:0]  len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] span;
        incr = a + (ADDR_WIDTH'(1) << size);
        span = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        case (burst)
            2'b01:   next_addr = incr;
            2'b10:   next_addr = (a & ~(span - 1'b1)) | (incr & (span - 1'b1));
            default: next_addr = a;
        endcase
    endfunction

    function automatic logic cfg_bad(
        input logic [2:0]           size,
        input logic [LEN_WIDTH-1:0] len,
        input logic [1:0]           burst
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                      (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
        cfg_bad = (size > MAX_SIZE) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        out_of_range = {1'b0, a} >= MEM_BYTES;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write channel ----------------
    w_state_t              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, w_next_addr;
    logic [LEN_WIDTH-1:0]  aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic                  w_cfg_err_q, w_cfg_err_d, w_err_q, w_err_d;
    logic                  w_beat_err, mem_we;
    logic [IDXW-1:0]       mem_widx;

    assign w_next_addr = next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
    assign w_beat_err  = w_cfg_err_q || out_of_range(aw_addr_q);
    assign mem_widx    = aw_addr_q[OFF +: IDXW];

    always_comb begin
        w_state_d   = w_state_q;
        aw_id_d     = aw_id_q;
        aw_addr_d   = aw_addr_q;
        aw_len_d    = aw_len_q;
        aw_size_d   = aw_size_q;
        aw_burst_d  = aw_burst_q;
        w_cnt_d     = w_cnt_q;
        w_cfg_err_d = w_cfg_err_q;
        w_err_d     = w_err_q;
        mem_we      = 1'b0;
        case (w_state_q)
            W_IDLE: if (awvalid) begin
                aw_id_d     = awid;
                aw_addr_d   = awaddr;
                aw_len_d    = awlen;
                aw_size_d   = awsize;
                aw_burst_d  = awburst;
                w_cnt_d     = '0;
                w_cfg_err_d = cfg_bad(awsize, awlen, awburst);
                w_err_d     = 1'b0;
                w_state_d   = W_DATA;
            end
            W_DATA: if (wvalid) begin
                // Erroneous beats are still consumed so the burst length stays intact.
                mem_we    = !w_beat_err && !rst;
                w_err_d   = w_err_q || w_beat_err || (wlast != (w_cnt_q == aw_len_q));
                aw_addr_d = w_next_addr;
                w_cnt_d   = w_cnt_q + 1'b1;
                if (w_cnt_q == aw_len_q) w_state_d = W_RESP;
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            aw_id_q     <= '0;
            aw_addr_q   <= '0;
            aw_len_q    <= '0;
            aw_size_q   <= '0;
            aw_burst_q  <= '0;
            w_cnt_q     <= '0;
            w_cfg_err_q <= 1'b0;
            w_err_q     <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            aw_id_q     <= aw_id_d;
            aw_addr_q   <= aw_addr_d;
            aw_len_q    <= aw_len_d;
            aw_size_q   <= aw_size_d;
            aw_burst_q  <= aw_burst_d;
            w_cnt_q     <= w_cnt_d;
            w_cfg_err_q <= w_cfg_err_d;
            w_err_q     <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) mem[mem_widx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = bvalid ? aw_id_q : '0;
    assign bresp   = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read channel ----------------
    r_state_t              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, r_next_addr, r_load_addr;
    logic [LEN_WIDTH-1:0]  ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic                  r_cfg_err_q, r_cfg_err_d, rlast_q, rlast_d;
    logic                  r_load, r_load_err, r_clear;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    assign r_next_addr = next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);

    always_comb begin
        r_state_d   = r_state_q;
        rid_d       = rid_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        ar_burst_d  = ar_burst_q;
        r_cnt_d     = r_cnt_q;
        r_cfg_err_d = r_cfg_err_q;
        rlast_d     = rlast_q;
        r_load      = 1'b0;
        r_load_addr = r_next_addr;
        r_clear     = 1'b0;
        case (r_state_q)
            R_IDLE: if (arvalid) begin
                rid_d       = arid;
                ar_addr_d   = araddr;
                ar_len_d    = arlen;
                ar_size_d   = arsize;
                ar_burst_d  = arburst;
                r_cnt_d     = '0;
                r_cfg_err_d = cfg_bad(arsize, arlen, arburst);
                rlast_d     = (arlen == '0);
                r_load      = 1'b1;
                r_load_addr = araddr;
                r_state_d   = R_DATA;
            end
            R_DATA: if (rready) begin
                if (r_cnt_q == ar_len_q) begin
                    rid_d     = '0;
                    rlast_d   = 1'b0;
                    r_clear   = 1'b1;
                    r_state_d = R_IDLE;
                end else begin
                    // Prefetch the next beat so it is presented without a bubble.
                    ar_addr_d = r_next_addr;
                    r_cnt_d   = r_cnt_q + 1'b1;
                    rlast_d   = (r_cnt_d == ar_len_q);
                    r_load    = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        r_load_err = r_cfg_err_d || out_of_range(r_load_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= R_IDLE;
            rid_q       <= '0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            ar_size_q   <= '0;
            ar_burst_q  <= '0;
            r_cnt_q     <= '0;
            r_cfg_err_q <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            r_state_q   <= r_state_d;
            rid_q       <= rid_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            ar_size_q   <= ar_size_d;
            ar_burst_q  <= ar_burst_d;
            r_cnt_q     <= r_cnt_d;
            r_cfg_err_q <= r_cfg_err_d;
            rlast_q     <= rlast_d;
            if (r_load) begin
                rdata_q <= r_load_err ? '0 : mem[r_load_addr[OFF +: IDXW]];
                rresp_q <= r_load_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_clear) begin
                rdata_q <= '0;
                rresp_q <= RESP_OKAY;
            end
        end
    end

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, wrap, strobes, back-pressure, errors, reset.
module tb_axi_slave_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wd     [16];
    logic [31:0] exp_rd [16];
    logic [1:0]  exp_rr [16];

    always #5 clk = ~clk;

    axi_slave_mem dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb,
                            input int bad_last_beat, input logic [1:0] exp_bresp);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        chk("awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wd[b]; wstrb = strb; wvalid = 1'b1;
            wlast = (b == int'(len)) || (b == bad_last_beat);
            n = 0;
            while (!wready && n < 50) begin tick(); n++; end
            chk("wready", {31'd0, wready}, 32'd1);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, {30'd0, exp_bresp});
        chk("bid", {28'd0, bid}, {28'd0, id});
        tick();
        bready = 1'b0;
        chk("awready_after_b", {31'd0, awready}, 32'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_beat);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        chk("arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0; rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < 50) begin tick(); n++; end
            chk("rvalid", {31'd0, rvalid}, 32'd1);
            chk("rdata", rdata, exp_rd[b]);
            chk("rresp", {30'd0, rresp}, {30'd0, exp_rr[b]});
            chk("rlast", {31'd0, rlast}, (b == int'(len)) ? 32'd1 : 32'd0);
            chk("rid", {28'd0, rid}, {28'd0, id});
            if (b == stall_beat) begin
                rready = 1'b0;
                repeat (5) begin
                    tick();
                    chk("stall_rvalid", {31'd0, rvalid}, 32'd1);
                    chk("stall_rdata", rdata, exp_rd[b]);
                    chk("stall_rlast", {31'd0, rlast}, (b == int'(len)) ? 32'd1 : 32'd0);
                    chk("stall_rid", {28'd0, rid}, {28'd0, id});
                end
                rready = 1'b1;
            end
            tick();
        end
        rready = 1'b0;
        chk("rvalid_end", {31'd0, rvalid}, 32'd0);
        chk("arready_end", {31'd0, arready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_rlast",   {31'd0, rlast},   32'd0);
        chk("rst_bid",     {28'd0, bid},     32'd0);
        chk("rst_rid",     {28'd0, rid},     32'd0);
        chk("rst_bresp",   {30'd0, bresp},   32'd0);
        chk("rst_rresp",   {30'd0, rresp},   32'd0);
        chk("rst_rdata",   rdata,            32'd0);

        // INCR write then read back
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        do_write(4'd3, 32'h10, 8'd3, 2'b01, 4'hF, -1, 2'b00);
        exp_rd[0] = 32'hA0; exp_rd[1] = 32'hA1; exp_rd[2] = 32'hA2; exp_rd[3] = 32'hA3;
        for (int i = 0; i < 4; i++) exp_rr[i] = 2'b00;
        do_read(4'd3, 32'h10, 8'd3, 2'b01, -1);

        // WRAP read: words 0x38,0x3C,0x30,0x34
        wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2; wd[3] = 32'hB3;
        do_write(4'd5, 32'h30, 8'd3, 2'b01, 4'hF, -1, 2'b00);
        exp_rd[0] = 32'hB2; exp_rd[1] = 32'hB3; exp_rd[2] = 32'hB0; exp_rd[3] = 32'hB1;
        do_read(4'd6, 32'h38, 8'd3, 2'b10, -1);

        // Partial strobe over an all-ones word
        wd[0] = 32'hFFFF_FFFF;
        do_write(4'd1, 32'h40, 8'd0, 2'b01, 4'hF, -1, 2'b00);
        wd[0] = 32'h1234_5678;
        do_write(4'd1, 32'h40, 8'd0, 2'b01, 4'h3, -1, 2'b00);
        exp_rd[0] = 32'hFFFF_5678; exp_rr[0] = 2'b00;
        do_read(4'd2, 32'h40, 8'd0, 2'b01, -1);

        // Back-pressure for 5 cycles on beat 1
        exp_rd[0] = 32'hA0; exp_rd[1] = 32'hA1; exp_rd[2] = 32'hA2; exp_rd[3] = 32'hA3;
        for (int i = 0; i < 4; i++) exp_rr[i] = 2'b00;
        do_read(4'd9, 32'h10, 8'd3, 2'b01, 1);

        // Out-of-range write: SLVERR and the aliased word 0 stays intact
        wd[0] = 32'h1111_1111;
        do_write(4'd4, 32'h0, 8'd0, 2'b01, 4'hF, -1, 2'b00);
        wd[0] = 32'hDEAD_BEEF;
        do_write(4'd4, 32'h400, 8'd0, 2'b01, 4'hF, -1, 2'b10);
        exp_rd[0] = 32'h1111_1111; exp_rr[0] = 2'b00;
        do_read(4'd4, 32'h0, 8'd0, 2'b01, -1);
        exp_rd[0] = 32'h0; exp_rr[0] = 2'b10;
        do_read(4'd7, 32'h400, 8'd0, 2'b01, -1);

        // Reserved burst type: SLVERR and memory unchanged
        wd[0] = 32'h77;
        do_write(4'd8, 32'h50, 8'd0, 2'b01, 4'hF, -1, 2'b00);
        wd[0] = 32'h55;
        do_write(4'd8, 32'h50, 8'd0, 2'b11, 4'hF, -1, 2'b10);
        exp_rd[0] = 32'h77; exp_rr[0] = 2'b00;
        do_read(4'd8, 32'h50, 8'd0, 2'b01, -1);

        // WRAP with illegal length: every beat SLVERR with zero data
        for (int i = 0; i < 3; i++) begin exp_rd[i] = 32'h0; exp_rr[i] = 2'b10; end
        do_read(4'd10, 32'h30, 8'd2, 2'b10, -1);

        // Early wlast: all 4 beats consumed, SLVERR
        wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; wd[3] = 32'hC3;
        do_write(4'd12, 32'h60, 8'd3, 2'b01, 4'hF, 1, 2'b10);

        // Reset in the middle of a read burst
        arid = 4'd11; araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0; rready = 1'b1;
        tick();
        chk("midrst_beat1", rdata, 32'hA1);
        rready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("midrst_arready", {31'd0, arready}, 32'd1);
        chk("midrst_rlast",   {31'd0, rlast},   32'd0);
        chk("midrst_rdata",   rdata,            32'd0);
        chk("midrst_rid",     {28'd0, rid},     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
